mapu_feeder: RTL and testbench
==============================

# mapu_feeder

Host-side feeder for the Matrix APU input port. It gathers 4x4 matrices one element at a time from a simple register-write port and holds up to two committed matrices with their opcodes. It drives them to `mapu_top` one matrix per beat over the MAPU valid/ready input handshake. It sits between the control-plane write bus and the `i_*` side of `mapu_top`.

## Interface
Parameters:
- `DATA_W`, 8: element width in bits; each row is 4*`DATA_W` bits, with column 0 in the LSBs.
- `OP_W`, 2: opcode width.
- `CNT_W`, 16: width of the sent-beat counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `h_we`  in  1  element write strobe.
- `h_addr`  in  4  element index: row = `h_addr[3:2]`, column = `h_addr[1:0]`.
- `h_wdata`  in  `DATA_W`  element value.
- `h_commit`  in  1  pushes the staged matrix and `h_op` into the queue.
- `h_op`  in  `OP_W`  opcode captured with the commit.
- `h_enable`  in  1  permits new beats to be launched.
- `h_full`  out  1  queue holds 2 matrices.
- `h_drop_err`  out  1  sticky flag: a commit was dropped.
- `h_err_clr`  in  1  clears `h_drop_err`.
- `h_sent`  out  `CNT_W`  number of completed beats; wraps.
- `m_en`  out  1  MAPU enable.
- `m_op`  out  `OP_W`  opcode for the current beat.
- `m_vld`  out  1  beat valid.
- `m_rdy`  in  1  MAPU ready to accept a beat.
- `m_r0`..`m_r3`  out  4*`DATA_W` each  matrix rows 0..3.

## Operation
Staging register (16 elements):
- `h_we` writes the element at `h_addr`.
- `h_commit` copies the staging register, with `h_op`, into the queue tail. The staging register is then cleared to zero, so any element not written before a commit goes out as 0.
- If `h_we` and `h_commit` occur in the same cycle, the write is included in the committed matrix.

Queue, two entries (states EMPTY, ONE, FULL):
- Commit only: EMPTY→ONE, ONE→FULL.
- Pop only: FULL→ONE, ONE→EMPTY.
- Commit and pop in the same cycle: the state is unchanged.
- Commit while FULL with no pop in that cycle: the matrix is dropped, `h_drop_err` is set, the queue is unchanged, and staging is still cleared.
- Commit while FULL with a pop in the same cycle: the commit is accepted.

Output side:
- `m_r*` and `m_op` always reflect the queue head.
- `m_vld` rises only when the queue is not EMPTY and `h_enable` = 1.
- Once `m_vld` is high, it and the data stay stable until `m_vld && m_rdy`, even if `h_enable` drops.
- A transfer occurs on `m_vld && m_rdy`: the head is popped and `h_sent` increments, wrapping from 2^`CNT_W`-1 to 0.
- `m_en` = registered `h_enable`.

Flags:
- `h_full` = (state == FULL).
- If `h_err_clr` and a new drop occur in the same cycle, the set wins.

## Timing
- Reset values: `m_vld`=0, `m_en`=0, `m_op`=0, `m_r*`=0, `h_full`=0, `h_drop_err`=0, `h_sent`=0. Staging and both entries are cleared.
- Reset asserted mid-transfer aborts immediately: queued data is discarded and `m_vld` drops asynchronously.
- Commit in cycle N into an EMPTY queue with `h_enable`=1: `m_vld`=1 in cycle N+1. No combinational path exists from `h_*` to `m_*`.
- Back-to-back: with 2 queued and `m_rdy` held at 1, beats transfer in consecutive cycles. Sustained throughput is 1 beat/cycle when commits arrive every cycle.
- `h_enable` rising in cycle N with a non-empty queue: `m_vld`=1 in cycle N+1, and `m_en`=1 in cycle N+1.
- `h_full` and `h_sent` update in the cycle after the causing event.
- `m_rdy` may be high while `m_vld` is low; no transfer occurs.

## Test plan
- Reset, write elements 0..15 with values 0x10..0x1F, commit with op=2, `m_rdy`=1 → one beat in the cycle after the commit. `m_r0`=0x13121110, `m_r3`=0x1F1E1D1C, `m_op`=2, `h_sent`=1, then `m_vld`=0.
- Write only addr 5 = 0xAA, then commit → `m_r1`=0x0000AA00 and all other rows 0. A second commit with no writes sends an all-zero matrix.
- `m_rdy`=0 with 3 commits → after two commits `h_full`=1, the third is dropped and `h_drop_err`=1. `m_r*` stays stable until `m_rdy`=1. Exactly 2 beats are then sent, in order; `h_err_clr` → `h_drop_err`=0.
- FULL queue with `m_rdy`=1 and a commit in the same cycle → the commit is accepted, `h_drop_err` stays 0, and 3 beats are eventually sent.
- `m_vld` high, then `h_enable` drops before `m_rdy` → the beat is held and completes. The next queued matrix is not launched until `h_enable`=1.
- Assert `reset_n`=0 mid-stream with 2 queued → `m_vld`=0 immediately and `h_sent`=0. After release there are no beats until a new commit.

Source files
------------

// File: rtl/mapu_feeder.sv
// Host-side feeder for the Matrix APU: stages a 4x4 matrix element by element, queues up to
// two committed matrices with their opcodes and launches them one per valid/ready beat.
module mapu_feeder #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  h_we,
    input  logic [3:0]            h_addr,
    input  logic [DATA_W-1:0]     h_wdata,
    input  logic                  h_commit,
    input  logic [OP_W-1:0]       h_op,
    input  logic                  h_enable,
    output logic                  h_full,
    output logic                  h_drop_err,
    input  logic                  h_err_clr,
    output logic [CNT_W-1:0]      h_sent,
    output logic                  m_en,
    output logic [OP_W-1:0]       m_op,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic [4*DATA_W-1:0]   m_r0,
    output logic [4*DATA_W-1:0]   m_r1,
    output logic [4*DATA_W-1:0]   m_r2,
    output logic [4*DATA_W-1:0]   m_r3
);

    // Element i sits at bits [i*DATA_W +: DATA_W], so each row slice has column 0 in the LSBs.
    typedef logic [15:0][DATA_W-1:0] mat_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        mat_t            mat;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_e;

    q_state_e         state_q, state_d;
    mat_t             stage_q, stage_d, stage_wr;
    entry_t           head_q, head_d, tail_q, tail_d;
    entry_t           new_entry;
    logic             vld_q, vld_d;
    logic             en_q;
    logic [CNT_W-1:0] sent_q;
    logic             drop_err_q, drop_err_d;
    logic             xfer, push, drop;

    assign xfer      = vld_q & m_rdy;
    assign push      = h_commit & ((state_q != FULL) | xfer);
    assign drop      = h_commit & (state_q == FULL) & ~xfer;
    assign new_entry = {h_op, stage_wr};

    // A write in the commit cycle is merged into the committed matrix.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stage_wr = stage_q;
        if (h_we) stage_wr[h_addr] = h_wdata;
        stage_d = h_commit ? '0 : stage_wr;
    end

    // Queue FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // Queue FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !xfer)      state_d = FULL;
                else if (xfer && !push) state_d = EMPTY;
            end
            FULL:    if (xfer && !push) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Queue FSM: outputs.
    always_comb begin
        h_full = (state_q == FULL);
    end

    // Entry datapath: head is always entry 0; a pop shifts the tail forward.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        unique case (state_q)
            EMPTY: if (push) head_d = new_entry;
            ONE: begin
                if (push && xfer) head_d = new_entry;
                else if (push)    tail_d = new_entry;
            end
            FULL: begin
                if (xfer) begin
                    head_d = tail_q;
                    if (push) tail_d = new_entry;
                end
            end
            default: ;
        endcase
    end

    // Once raised, valid holds until accepted regardless of h_enable.
    always_comb begin
        if (vld_q && !m_rdy) vld_d = 1'b1;
        else                 vld_d = (state_d != EMPTY) && h_enable;
        if (drop)           drop_err_d = 1'b1;
        else if (h_err_clr) drop_err_d = 1'b0;
        else                drop_err_d = drop_err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: staging and entries are reset because reset must discard queued data, not just flags.
        if (!reset_n) begin
            stage_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            vld_q      <= 1'b0;
            en_q       <= 1'b0;
            sent_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            vld_q      <= vld_d;
            en_q       <= h_enable;
            sent_q     <= xfer ? sent_q + 1'b1 : sent_q;
            drop_err_q <= drop_err_d;
        end
    end

    assign h_drop_err = drop_err_q;
    assign h_sent     = sent_q;
    assign m_en       = en_q;
    assign m_vld      = vld_q;
    assign m_op       = head_q.op;
    assign m_r0       = head_q.mat[3:0];
    assign m_r1       = head_q.mat[7:4];
    assign m_r2       = head_q.mat[11:8];
    assign m_r3       = head_q.mat[15:12];

endmodule

// File: tb/tb_mapu_feeder.sv
// Directed bench for mapu_feeder: staging, queue fill/drop, handshake hold and async reset.
module tb_mapu_feeder;

    localparam int DATA_W = 8;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                h_we, h_commit, h_enable, h_err_clr, m_rdy;
    logic [3:0]          h_addr;
    logic [DATA_W-1:0]   h_wdata;
    logic [OP_W-1:0]     h_op, m_op;
    logic                h_full, h_drop_err, m_en, m_vld;
    logic [CNT_W-1:0]    h_sent;
    logic [4*DATA_W-1:0] m_r0, m_r1, m_r2, m_r3;

    int n_checks = 0;
    int n_fail   = 0;

    mapu_feeder #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_commit(h_commit), .h_op(h_op), .h_enable(h_enable),
        .h_full(h_full), .h_drop_err(h_drop_err), .h_err_clr(h_err_clr),
        .h_sent(h_sent), .m_en(m_en), .m_op(m_op), .m_vld(m_vld), .m_rdy(m_rdy),
        .m_r0(m_r0), .m_r1(m_r1), .m_r2(m_r2), .m_r3(m_r3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [DATA_W-1:0] d);
        h_we = 1'b1; h_addr = a; h_wdata = d;
        step();
        h_we = 1'b0;
    endtask

    task automatic commit(input logic [OP_W-1:0] op);
        h_commit = 1'b1; h_op = op;
        step();
        h_commit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_commit = 1'b0;
        h_op = '0; h_enable = 1'b0; h_err_clr = 1'b0; m_rdy = 1'b0;
        #12;
        check("rst_vld", m_vld, 0);
        check("rst_en", m_en, 0);
        check("rst_op", m_op, 0);
        check("rst_r0", m_r0, 0);
        check("rst_r3", m_r3, 0);
        check("rst_full", h_full, 0);
        check("rst_err", h_drop_err, 0);
        check("rst_sent", h_sent, 0);
        reset_n = 1'b1;
        step();

        // Full matrix, last element written in the commit cycle.
        h_enable = 1'b1; m_rdy = 1'b1;
        step();
        check("en_reg", m_en, 1);
        for (int i = 0; i < 15; i++) wr(4'(i), 8'(8'h10 + i));
        h_we = 1'b1; h_addr = 4'd15; h_wdata = 8'h1F;
        commit(2'd2);
        h_we = 1'b0;
        check("t1_vld", m_vld, 1);
        check("t1_r0", m_r0, 32'h13121110);
        check("t1_r1", m_r1, 32'h17161514);
        check("t1_r3", m_r3, 32'h1F1E1D1C);
        check("t1_op", m_op, 2);
        step();
        check("t1_sent", h_sent, 1);
        check("t1_vld_lo", m_vld, 0);

        // Sparse write, then an all-zero commit.
        wr(4'd5, 8'hAA);
        commit(2'd1);
        check("t2_r0", m_r0, 0);
        check("t2_r1", m_r1, 32'h0000AA00);
        check("t2_r2", m_r2, 0);
        check("t2_r3", m_r3, 0);
        check("t2_op", m_op, 1);
        step();
        check("t2_sent", h_sent, 2);
        commit(2'd3);
        check("t2z_vld", m_vld, 1);
        check("t2z_r1", m_r1, 0);
        check("t2z_op", m_op, 3);
        step();
        check("t2z_sent", h_sent, 3);

        // Fill with m_rdy low, third commit dropped.
        m_rdy = 1'b0;
        wr(4'd0, 8'h01); commit(2'd1);
        check("t3_full0", h_full, 0);
        wr(4'd0, 8'h02); commit(2'd2);
        check("t3_full1", h_full, 1);
        wr(4'd0, 8'h03); commit(2'd3);
        check("t3_err", h_drop_err, 1);
        check("t3_full2", h_full, 1);
        step(); step();
        check("t3_hold_r0", m_r0, 32'h01);
        check("t3_hold_op", m_op, 1);
        check("t3_hold_vld", m_vld, 1);
        m_rdy = 1'b1;
        step();
        check("t3_b2_r0", m_r0, 32'h02);
        check("t3_b2_op", m_op, 2);
        check("t3_b2_vld", m_vld, 1);
        check("t3_b1_sent", h_sent, 4);
        check("t3_full3", h_full, 0);
        step();
        check("t3_sent", h_sent, 5);
        check("t3_idle", m_vld, 0);
        check("t3_err_sticky", h_drop_err, 1);
        h_err_clr = 1'b1;
        step();
        h_err_clr = 1'b0;
        check("t3_err_clr", h_drop_err, 0);

        // Commit into FULL with a pop in the same cycle is accepted.
        m_rdy = 1'b0;
        wr(4'd1, 8'h11); commit(2'd0);
        check("t4_stage_clr", m_r0, 32'h00001100);
        wr(4'd0, 8'h22); commit(2'd1);
        check("t4_full", h_full, 1);
        m_rdy = 1'b1; h_we = 1'b1; h_addr = 4'd0; h_wdata = 8'h33;
        commit(2'd2);
        h_we = 1'b0;
        check("t4_noerr", h_drop_err, 0);
        check("t4_full_kept", h_full, 1);
        check("t4_r0_b", m_r0, 32'h22);
        check("t4_sent6", h_sent, 6);
        step();
        check("t4_r0_c", m_r0, 32'h33);
        check("t4_op_c", m_op, 2);
        check("t4_sent7", h_sent, 7);
        step();
        check("t4_sent8", h_sent, 8);
        check("t4_idle", m_vld, 0);

        // Valid holds when h_enable drops; next beat waits for enable.
        m_rdy = 1'b0;
        wr(4'd0, 8'h44); commit(2'd0);
        check("t5_vld", m_vld, 1);
        wr(4'd0, 8'h55); commit(2'd1);
        h_enable = 1'b0;
        step();
        check("t5_en_lo", m_en, 0);
        check("t5_hold", m_vld, 1);
        check("t5_hold_r0", m_r0, 32'h44);
        m_rdy = 1'b1;
        step();
        check("t5_sent9", h_sent, 9);
        check("t5_no_launch", m_vld, 0);
        check("t5_head", m_r0, 32'h55);
        step(); step();
        check("t5_rdy_no_vld", h_sent, 9);
        h_enable = 1'b1;
        step();
        check("t5_relaunch", m_vld, 1);
        check("t5_en_hi", m_en, 1);
        step();
        check("t5_sent10", h_sent, 10);

        // Async reset with two queued entries.
        m_rdy = 1'b0;
        wr(4'd0, 8'h66); commit(2'd1);
        wr(4'd0, 8'h77); commit(2'd2);
        check("t6_pre_full", h_full, 1);
        reset_n = 1'b0;
        #1;
        check("t6_vld_async", m_vld, 0);
        check("t6_sent_async", h_sent, 0);
        check("t6_full_async", h_full, 0);
        check("t6_r0_async", m_r0, 0);
        step();
        reset_n = 1'b1; m_rdy = 1'b1;
        step(); step(); step();
        check("t6_no_beat", m_vld, 0);
        check("t6_sent0", h_sent, 0);
        wr(4'd15, 8'h99); commit(2'd2);
        check("t6_new_vld", m_vld, 1);
        check("t6_new_r3", m_r3, 32'h99000000);
        check("t6_new_r0", m_r0, 0);
        step();
        check("t6_sent1", h_sent, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
